// File: rtl/cpu_test_monitor_if.sv
// Signal bundle between the CPU-side harness (master) and the checkpoint monitor (slave).
// The master loads the table, starts runs and drives the CPU observation signals.
interface cpu_test_monitor_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_TEST  = 64,
    parameter int CYC_W     = 32
);
    localparam int IDX_W = (NUM_TEST > 1) ? $clog2(NUM_TEST) : 1;
    localparam int CNT_W = $clog2(NUM_TEST + 1);

    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [WORD_SIZE-1:0] cfg_inst;
    logic [WORD_SIZE-1:0] cfg_ans;
    logic                 start;
    logic [CNT_W-1:0]     test_len;
    logic [WORD_SIZE-1:0] num_inst;
    logic [WORD_SIZE-1:0] output_port;
    logic                 is_halted;
    logic                 busy;
    logic                 done;
    logic                 all_pass;
    logic                 timed_out;
    logic                 halted_seen;
    logic [CNT_W-1:0]     pass_count;
    logic [CNT_W-1:0]     fail_count;
    logic [CNT_W-1:0]     miss_count;
    logic [CNT_W-1:0]     cur_idx;
    logic [CYC_W-1:0]     cycle_count;
    logic [IDX_W-1:0]     rd_idx;
    logic [1:0]           rd_status;

    modport master (
        output cfg_we, cfg_idx, cfg_inst, cfg_ans, start, test_len,
        output num_inst, output_port, is_halted, rd_idx,
        input  busy, done, all_pass, timed_out, halted_seen,
        input  pass_count, fail_count, miss_count, cur_idx, cycle_count, rd_status
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_inst, cfg_ans, start, test_len,
        input  num_inst, output_port, is_halted, rd_idx,
        output busy, done, all_pass, timed_out, halted_seen,
        output pass_count, fail_count, miss_count, cur_idx, cycle_count, rd_status
    );
endinterface

// File: rtl/cpu_test_monitor.sv
// Checkpoint scoreboard for the multi-cycle CPU: compares output_port against a table of
// (instruction count, expected value) entries, one entry per cycle, in table order.
module cpu_test_monitor #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_TEST   = 64,
    parameter int CYC_W      = 32,
    parameter int MAX_CYCLES = 20000
) (
    input logic               clk,
    input logic               reset,
    cpu_test_monitor_if.slave mon
);
    localparam int IDX_W = (NUM_TEST > 1) ? $clog2(NUM_TEST) : 1;
    localparam int CNT_W = $clog2(NUM_TEST + 1);
    localparam logic [CNT_W-1:0] NUM_TEST_C = CNT_W'(NUM_TEST);
    localparam logic [IDX_W:0]   NUM_TEST_I = (IDX_W + 1)'(NUM_TEST);
    localparam logic [CYC_W-1:0] MAX_CYC_C  = CYC_W'(MAX_CYCLES);

    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_PASS = 2'b01;
    localparam logic [1:0] S_FAIL = 2'b10;
    localparam logic [1:0] S_MISS = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     len_reg, len_next;
    logic [CNT_W-1:0]     cur_idx_reg, cur_idx_next;
    logic [CNT_W-1:0]     pass_reg, pass_next;
    logic [CNT_W-1:0]     fail_reg, fail_next;
    logic [CNT_W-1:0]     miss_reg, miss_next;
    logic [CYC_W-1:0]     cyc_reg, cyc_next;
    logic                 timed_out_reg, timed_out_next;
    logic                 halted_reg, halted_next;

    logic                 st_we;
    logic [1:0]           st_code;
    logic                 clear_status;

    logic [WORD_SIZE-1:0] tbl_inst [NUM_TEST];
    logic [WORD_SIZE-1:0] tbl_ans  [NUM_TEST];
    logic [1:0]           status_reg  [NUM_TEST];
    logic [1:0]           status_next [NUM_TEST];

    logic                 cfg_ok;
    logic                 rd_ok;
    logic [IDX_W-1:0]     ent_idx;
    logic [WORD_SIZE-1:0] e_inst;
    logic [WORD_SIZE-1:0] e_ans;
    logic [CNT_W-1:0]     start_len;

    assign cfg_ok    = {1'b0, mon.cfg_idx} < NUM_TEST_I;
    assign rd_ok     = {1'b0, mon.rd_idx} < NUM_TEST_I;
    assign ent_idx   = cur_idx_reg[IDX_W-1:0];
    assign e_inst    = tbl_inst[ent_idx];
    assign e_ans     = tbl_ans[ent_idx];
    assign start_len = (mon.test_len > NUM_TEST_C) ? NUM_TEST_C : mon.test_len;

    // Table is not reset; a write issued together with start lands before the first RUN read.
    always_ff @(posedge clk) begin
        if (mon.cfg_we && state_reg != ST_RUN && cfg_ok) begin
            tbl_inst[mon.cfg_idx] <= mon.cfg_inst;
            tbl_ans[mon.cfg_idx]  <= mon.cfg_ans;
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        cur_idx_next   = cur_idx_reg;
        pass_next      = pass_reg;
        fail_next      = fail_reg;
        miss_next      = miss_reg;
        cyc_next       = cyc_reg;
        timed_out_next = timed_out_reg;
        halted_next    = halted_reg;
        st_we          = 1'b0;
        st_code        = S_NONE;
        clear_status   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (mon.start) begin
                    clear_status   = 1'b1;
                    len_next       = start_len;
                    cur_idx_next   = '0;
                    pass_next      = '0;
                    fail_next      = '0;
                    miss_next      = '0;
                    cyc_next       = '0;
                    timed_out_next = 1'b0;
                    halted_next    = 1'b0;
                    state_next     = (start_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                cyc_next = cyc_reg + 1'b1;
                if (mon.num_inst == e_inst) begin
                    st_we        = 1'b1;
                    cur_idx_next = cur_idx_reg + 1'b1;
                    if (mon.output_port == e_ans) begin
                        st_code   = S_PASS;
                        pass_next = pass_reg + 1'b1;
                    end else begin
                        st_code   = S_FAIL;
                        fail_next = fail_reg + 1'b1;
                    end
                end else if (mon.num_inst > e_inst) begin
                    st_we        = 1'b1;
                    st_code      = S_MISS;
                    miss_next    = miss_reg + 1'b1;
                    cur_idx_next = cur_idx_reg + 1'b1;
                end
                // End conditions see this cycle's compare; only the highest-priority one is flagged.
                if (cur_idx_next == len_reg) begin
                    state_next = ST_DONE;
                end else if (mon.is_halted) begin
                    halted_next = 1'b1;
                    state_next  = ST_DONE;
                end else if (cyc_next == MAX_CYC_C) begin
                    timed_out_next = 1'b1;
                    state_next     = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_TEST; gi++) begin : g_status
        assign status_next[gi] = clear_status ? S_NONE :
                                 (st_we && ent_idx == IDX_W'(gi)) ? st_code : status_reg[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            cur_idx_reg   <= '0;
            pass_reg      <= '0;
            fail_reg      <= '0;
            miss_reg      <= '0;
            cyc_reg       <= '0;
            timed_out_reg <= 1'b0;
            halted_reg    <= 1'b0;
            for (int i = 0; i < NUM_TEST; i++) status_reg[i] <= S_NONE;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            cur_idx_reg   <= cur_idx_next;
            pass_reg      <= pass_next;
            fail_reg      <= fail_next;
            miss_reg      <= miss_next;
            cyc_reg       <= cyc_next;
            timed_out_reg <= timed_out_next;
            halted_reg    <= halted_next;
            status_reg    <= status_next;
        end
    end

    // A zero-length run never passes, even though pass_count equals the length.
    assign mon.busy        = (state_reg == ST_RUN);
    assign mon.done        = (state_reg == ST_DONE);
    assign mon.all_pass    = (state_reg == ST_DONE) && (len_reg != '0) && (pass_reg == len_reg);
    assign mon.timed_out   = timed_out_reg;
    assign mon.halted_seen = halted_reg;
    assign mon.pass_count  = pass_reg;
    assign mon.fail_count  = fail_reg;
    assign mon.miss_count  = miss_reg;
    assign mon.cur_idx     = cur_idx_reg;
    assign mon.cycle_count = cyc_reg;
    assign mon.rd_status   = rd_ok ? status_reg[mon.rd_idx] : S_NONE;
endmodule

// File: tb/tb_cpu_test_monitor.sv
// Bench for cpu_test_monitor: directed checkpoint scenarios plus random tables and traces,
// each run compared against a trace-walking reference model.
module tb_cpu_test_monitor;
    localparam int WS   = 16;
    localparam int NT   = 8;
    localparam int CW   = 32;
    localparam int MAXC = 30;
    localparam int TRL  = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_test_monitor_if #(.WORD_SIZE(WS), .NUM_TEST(NT), .CYC_W(CW)) bus ();

    cpu_test_monitor #(.WORD_SIZE(WS), .NUM_TEST(NT), .CYC_W(CW), .MAX_CYCLES(MAXC)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [WS-1:0] t_inst [NT];
    logic [WS-1:0] t_ans  [NT];
    logic [WS-1:0] tr_inst [TRL];
    logic [WS-1:0] tr_out  [TRL];
    bit            tr_halt [TRL];

    int       m_len, m_pass, m_fail, m_miss, m_idx, m_cyc;
    bit       m_to, m_halt;
    logic [1:0] m_st [NT];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks the trace one cycle at a time: the oldest unresolved entry is judged against
    // the instruction count seen that cycle, then the run-ending rules are applied.
    task automatic model(input int tlen);
        logic [WS-1:0] ni;
        int k;
        m_len  = (tlen > NT) ? NT : tlen;
        m_pass = 0; m_fail = 0; m_miss = 0; m_idx = 0; m_cyc = 0;
        m_to   = 0; m_halt = 0;
        for (int i = 0; i < NT; i++) m_st[i] = 2'b00;
        if (m_len == 0) return;
        for (k = 1; k <= TRL + 5; k++) begin
            ni = tr_inst[(k - 1 < TRL) ? k - 1 : TRL - 1];
            if (ni == t_inst[m_idx]) begin
                if (tr_out[(k - 1 < TRL) ? k - 1 : TRL - 1] == t_ans[m_idx]) begin
                    m_st[m_idx] = 2'b01; m_pass++;
                end else begin
                    m_st[m_idx] = 2'b10; m_fail++;
                end
                m_idx++;
            end else if (ni > t_inst[m_idx]) begin
                m_st[m_idx] = 2'b11; m_miss++; m_idx++;
            end
            m_cyc = k;
            if (m_idx == m_len) break;
            if (tr_halt[(k - 1 < TRL) ? k - 1 : TRL - 1]) begin m_halt = 1; break; end
            if (k == MAXC) begin m_to = 1; break; end
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < NT; i++) begin
            bus.cfg_we = 1'b1; bus.cfg_idx = 3'(i);
            bus.cfg_inst = t_inst[i]; bus.cfg_ans = t_ans[i];
            @(negedge clk);
        end
        bus.cfg_we = 1'b0;
    endtask

    // mode 0: plain run; 1: rewrite entry 2 mid-run (must be ignored); 2: rewrite entry 0 with start.
    task automatic run(input int tlen, input string tag, input int mode);
        bit ok = 0;
        if (mode == 2) t_ans[0] = 16'h0042;
        model(tlen);
        bus.test_len = 4'(tlen);
        bus.start = 1'b1;
        bus.is_halted = 1'b0;
        if (mode == 2) begin
            bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0;
            bus.cfg_inst = t_inst[0]; bus.cfg_ans = 16'h0042;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.cfg_we = 1'b0;
        for (int c = 0; c < TRL + 5; c++) begin
            if (bus.done) begin ok = 1; break; end
            bus.num_inst    = tr_inst[(c < TRL) ? c : TRL - 1];
            bus.output_port = tr_out[(c < TRL) ? c : TRL - 1];
            bus.is_halted   = tr_halt[(c < TRL) ? c : TRL - 1];
            bus.cfg_we = (mode == 1 && c == 1);
            bus.cfg_idx = 3'd2; bus.cfg_inst = t_inst[2]; bus.cfg_ans = 16'hBEEF;
            @(negedge clk);
        end
        bus.cfg_we = 1'b0;
        bus.is_halted = 1'b0;
        check({tag, ".done_reached"}, 64'(ok), 64'd1);
        check({tag, ".busy"},        64'(bus.busy), 64'd0);
        check({tag, ".pass"},        64'(bus.pass_count), 64'(m_pass));
        check({tag, ".fail"},        64'(bus.fail_count), 64'(m_fail));
        check({tag, ".miss"},        64'(bus.miss_count), 64'(m_miss));
        check({tag, ".cur_idx"},     64'(bus.cur_idx), 64'(m_idx));
        check({tag, ".cycles"},      64'(bus.cycle_count), 64'(m_cyc));
        check({tag, ".timed_out"},   64'(bus.timed_out), 64'(m_to));
        check({tag, ".halted_seen"}, 64'(bus.halted_seen), 64'(m_halt));
        check({tag, ".all_pass"},    64'(bus.all_pass), 64'(m_len != 0 && m_pass == m_len));
        for (int i = 0; i < NT; i++) begin
            bus.rd_idx = 3'(i);
            #1;
            check($sformatf("%s.status%0d", tag, i), 64'(bus.rd_status), 64'(m_st[i]));
        end
        @(negedge clk);
    endtask

    task automatic default_table();
        t_inst[0] = 16'd3;  t_ans[0] = 16'h0000;
        t_inst[1] = 16'd5;  t_ans[1] = 16'h0000;
        t_inst[2] = 16'd11; t_ans[2] = 16'h0001;
        for (int i = 3; i < NT; i++) begin t_inst[i] = WS'(100 + i); t_ans[i] = WS'(i); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WS-1:0] cur;
        int j;
        bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_inst = 0; bus.cfg_ans = 0;
        bus.start = 0; bus.test_len = 0; bus.num_inst = 0; bus.output_port = 0;
        bus.is_halted = 0; bus.rd_idx = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.cycles", 64'(bus.cycle_count), 64'd0);
        check("reset.pass", 64'(bus.pass_count), 64'd0);
        check("reset.status", 64'(bus.rd_status), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: all three checkpoints pass
        default_table();
        load_all();
        for (int c = 0; c < TRL; c++) begin
            tr_inst[c] = (c < 12) ? WS'(c) : 16'd11;
            tr_out[c]  = (c >= 11) ? 16'h0001 : 16'h0000;
            tr_halt[c] = 0;
        end
        run(3, "t1", 0);
        check("t1.pass_const", 64'(bus.pass_count), 64'd3);
        check("t1.cycles_const", 64'(bus.cycle_count), 64'd12);
        check("t1.all_pass_const", 64'(bus.all_pass), 64'd1);

        // 2: wrong value at the last checkpoint
        for (int c = 11; c < TRL; c++) tr_out[c] = 16'h0002;
        run(3, "t2", 0);
        check("t2.fail_const", 64'(bus.fail_count), 64'd1);

        // 3: instruction count jumps over checkpoint 5
        for (int c = 0; c < TRL; c++) begin
            tr_inst[c] = (c < 4) ? WS'(c) : ((c < 9) ? WS'(c + 3) : 16'd11);
            tr_out[c]  = (tr_inst[c] == 16'd11) ? 16'h0001 : 16'h0000;
        end
        run(3, "t3", 0);
        check("t3.miss_const", 64'(bus.miss_count), 64'd1);

        // 4: CPU halts at instruction 4
        for (int c = 0; c < TRL; c++) begin
            tr_inst[c] = (c < 5) ? WS'(c) : 16'd4;
            tr_out[c]  = 16'h0000;
            tr_halt[c] = (c >= 4);
        end
        run(3, "t4", 0);
        check("t4.halted_const", 64'(bus.halted_seen), 64'd1);

        // 5: timeout, then restart and asynchronous reset mid-run
        for (int c = 0; c < TRL; c++) begin tr_inst[c] = 0; tr_out[c] = 0; tr_halt[c] = 0; end
        run(3, "t5", 0);
        check("t5.cycles_const", 64'(bus.cycle_count), 64'(MAXC));
        bus.test_len = 4'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5r.busy", 64'(bus.busy), 64'd1);
        check("t5r.cycles", 64'(bus.cycle_count), 64'd0);
        check("t5r.timed_out", 64'(bus.timed_out), 64'd0);
        bus.num_inst = 16'd3; bus.output_port = 16'h0000;
        @(negedge clk);
        check("t5r.pass", 64'(bus.pass_count), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t5r.rst_busy", 64'(bus.busy), 64'd0);
        check("t5r.rst_pass", 64'(bus.pass_count), 64'd0);
        check("t5r.rst_cycles", 64'(bus.cycle_count), 64'd0);
        bus.rd_idx = 3'd0; #1;
        check("t5r.rst_status", 64'(bus.rd_status), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5r.idle_done", 64'(bus.done), 64'd0);

        // 6: zero length, clamped length, write during run, write with start
        run(0, "t6a", 0);
        for (int i = 0; i < NT; i++) begin t_inst[i] = WS'(2 * i); t_ans[i] = WS'(i + 7); end
        load_all();
        for (int c = 0; c < TRL; c++) begin
            tr_inst[c] = WS'(c);
            tr_out[c]  = WS'(c / 2 + 7);
            tr_halt[c] = 0;
        end
        run(15, "t6b", 0);
        run(8, "t6c", 1);
        tr_out[0] = 16'h0042;
        run(8, "t6d", 2);

        // random tables and traces
        for (int it = 0; it < 20; it++) begin
            cur = WS'($urandom_range(0, 3));
            for (int i = 0; i < NT; i++) begin
                t_inst[i] = cur; t_ans[i] = WS'($urandom_range(0, 3));
                cur = cur + WS'($urandom_range(0, 3));
            end
            load_all();
            cur = 0;
            for (int c = 0; c < TRL; c++) begin
                tr_inst[c] = cur;
                j = -1;
                for (int i = NT - 1; i >= 0; i--) if (t_inst[i] == cur) j = i;
                tr_out[c] = (j >= 0 && $urandom_range(0, 3) != 0) ? t_ans[j] : WS'($urandom_range(0, 3));
                tr_halt[c] = ($urandom_range(0, 39) == 0);
                cur = cur + WS'($urandom_range(0, 2));
            end
            run(int'($urandom_range(0, 10)), $sformatf("rnd%0d", it), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
